// File: rtl/rtc_hms_clock.sv
// BCD hours/minutes/seconds real-time clock with 12/24-hour display, set mode
// and a single armable minute alarm. Digit outputs are registered from the time registers.
module rtc_hms_clock #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic       clk_100MHz,
  input  logic       reset_pb,
  input  logic       mode_12h,
  input  logic       set_en,
  input  logic       inc_hr,
  input  logic       inc_min,
  input  logic       alarm_we,
  input  logic [4:0] alarm_hh,
  input  logic [5:0] alarm_mm,
  input  logic       alarm_ack,
  output logic       sec_tick,
  output logic [3:0] hrs_tens,
  output logic [3:0] hrs_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       pm,
  output logic       alarm
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] PRE_MAX = CW'(DIV - 1);

  logic [CW-1:0] pre;
  logic [3:0] h_t, h_o, m_t, m_o, s_t, s_o;
  logic [3:0] n_h_t, n_h_o, n_m_t, n_m_o, n_s_t, n_s_o;
  logic [3:0] hi_t, hi_o, mi_t, mi_o;
  logic       tick, fire, alarm_valid, alarm_ok;
  logic [4:0] a_hh, nh_bin, hr_bin, disp_hr;
  logic [5:0] a_mm, nm_bin;
  logic [3:0] d_tens, d_ones;
  logic       pm_d;

  // Single-step increments of the current hour and minute, shared by set mode and the carry chain
  always_comb begin
    mi_t = m_t;
    mi_o = m_o + 4'd1;
    if (m_o == 4'd9) begin
      mi_o = 4'd0;
      mi_t = (m_t == 4'd5) ? 4'd0 : m_t + 4'd1;
    end
    hi_t = h_t;
    hi_o = h_o + 4'd1;
    if (h_t == 4'd2 && h_o == 4'd3) begin
      hi_t = 4'd0;
      hi_o = 4'd0;
    end else if (h_o == 4'd9) begin
      hi_t = h_t + 4'd1;
      hi_o = 4'd0;
    end
  end

  always_comb begin
    tick  = !set_en && (pre == PRE_MAX);
    n_h_t = h_t;
    n_h_o = h_o;
    n_m_t = m_t;
    n_m_o = m_o;
    n_s_t = s_t;
    n_s_o = s_o;
    if (set_en) begin
      n_s_t = 4'd0;
      n_s_o = 4'd0;
      if (inc_min) begin
        n_m_t = mi_t;
        n_m_o = mi_o;
      end
      if (inc_hr) begin
        n_h_t = hi_t;
        n_h_o = hi_o;
      end
    end else if (tick) begin
      if (s_o != 4'd9) begin
        n_s_o = s_o + 4'd1;
      end else if (s_t != 4'd5) begin
        n_s_o = 4'd0;
        n_s_t = s_t + 4'd1;
      end else begin
        n_s_o = 4'd0;
        n_s_t = 4'd0;
        n_m_t = mi_t;
        n_m_o = mi_o;
        if (m_t == 4'd5 && m_o == 4'd9) begin
          n_h_t = hi_t;
          n_h_o = hi_o;
        end
      end
    end
  end

  assign nh_bin   = 5'(n_h_t) * 5'd10 + 5'(n_h_o);
  assign nm_bin   = 6'(n_m_t) * 6'd10 + 6'(n_m_o);
  assign hr_bin   = 5'(h_t) * 5'd10 + 5'(h_o);
  assign alarm_ok = (alarm_hh <= 5'd23) && (alarm_mm <= 6'd59);
  // Ticks only happen outside set mode, so a set-mode match can never fire
  assign fire = tick && alarm_valid && (n_s_t == 4'd0) && (n_s_o == 4'd0) &&
                (nm_bin == a_mm) && (nh_bin == a_hh);

  always_comb begin
    disp_hr = hr_bin;
    if (mode_12h) begin
      if (hr_bin == 5'd0)       disp_hr = 5'd12;
      else if (hr_bin > 5'd12)  disp_hr = hr_bin - 5'd12;
    end
    if (disp_hr >= 5'd20)      d_tens = 4'd2;
    else if (disp_hr >= 5'd10) d_tens = 4'd1;
    else                       d_tens = 4'd0;
    d_ones = 4'(disp_hr - 5'(d_tens) * 5'd10);
    pm_d   = mode_12h && (hr_bin >= 5'd12);
  end

  always_ff @(posedge clk_100MHz or posedge reset_pb) begin
    if (reset_pb) begin
      pre         <= '0;
      h_t         <= 4'd1;
      h_o         <= 4'd2;
      m_t         <= 4'd0;
      m_o         <= 4'd0;
      s_t         <= 4'd0;
      s_o         <= 4'd0;
      sec_tick    <= 1'b0;
      alarm_valid <= 1'b0;
      a_hh        <= 5'd0;
      a_mm        <= 6'd0;
      alarm       <= 1'b0;
      hrs_tens    <= 4'd1;
      hrs_ones    <= 4'd2;
      min_tens    <= 4'd0;
      min_ones    <= 4'd0;
      sec_tens    <= 4'd0;
      sec_ones    <= 4'd0;
      pm          <= 1'b0;
    end else begin
      pre      <= (set_en || tick) ? '0 : pre + CW'(1);
      h_t      <= n_h_t;
      h_o      <= n_h_o;
      m_t      <= n_m_t;
      m_o      <= n_m_o;
      s_t      <= n_s_t;
      s_o      <= n_s_o;
      sec_tick <= tick;
      if (alarm_we) begin
        alarm_valid <= alarm_ok;
        if (alarm_ok) begin
          a_hh <= alarm_hh;
          a_mm <= alarm_mm;
        end
      end
      if (fire)           alarm <= 1'b1;
      else if (alarm_ack) alarm <= 1'b0;
      hrs_tens <= d_tens;
      hrs_ones <= d_ones;
      min_tens <= m_t;
      min_ones <= m_o;
      sec_tens <= s_t;
      sec_ones <= s_o;
      pm       <= pm_d;
    end
  end
endmodule

// File: tb/tb_rtc_hms_clock.sv
// Randomised bench for rtc_hms_clock (DIV=10) against a seconds-of-day reference model.
module tb_rtc_hms_clock;
  localparam int DIV = 10;

  logic clk_100MHz = 1'b0, reset_pb = 1'b1, mode_12h = 1'b0, set_en = 1'b0;
  logic inc_hr = 1'b0, inc_min = 1'b0, alarm_we = 1'b0, alarm_ack = 1'b0;
  logic [4:0] alarm_hh = '0;
  logic [5:0] alarm_mm = '0;
  logic sec_tick, pm, alarm;
  logic [3:0] hrs_tens, hrs_ones, min_tens, min_ones, sec_tens, sec_ones;
  logic [26:0] obs, expv;

  int total = 0, bad = 0;

  // reference model: time as seconds of day, display state lags one edge
  int m_tod, m_pre, m_ahh, m_amm, d_tod;
  bit m_valid, m_alarm, m_tick, d_mode;

  localparam logic [26:0] RESET_VEC = {4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};

  rtc_hms_clock #(.CLK_HZ(10), .TICK_HZ(1)) dut (
    .clk_100MHz(clk_100MHz), .reset_pb(reset_pb), .mode_12h(mode_12h), .set_en(set_en),
    .inc_hr(inc_hr), .inc_min(inc_min), .alarm_we(alarm_we), .alarm_hh(alarm_hh),
    .alarm_mm(alarm_mm), .alarm_ack(alarm_ack), .sec_tick(sec_tick),
    .hrs_tens(hrs_tens), .hrs_ones(hrs_ones), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .pm(pm), .alarm(alarm)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  assign obs = {hrs_tens, hrs_ones, min_tens, min_ones, sec_tens, sec_ones, pm, sec_tick, alarm};

  function automatic logic [26:0] exp_vec();
    int h, m, s, hd;
    logic p;
    h = d_tod / 3600; m = (d_tod / 60) % 60; s = d_tod % 60;
    hd = h; p = 1'b0;
    if (d_mode) begin
      p  = (h >= 12);
      hd = h % 12;
      if (hd == 0) hd = 12;
    end
    return {4'(hd / 10), 4'(hd % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            p, m_tick, m_alarm};
  endfunction

  task automatic model_reset();
    m_tod = 12 * 3600; m_pre = 0; m_valid = 0; m_ahh = 0; m_amm = 0;
    m_alarm = 0; m_tick = 0; d_tod = m_tod; d_mode = 0;
  endtask

  task automatic model_edge();
    int h, m;
    bit fire;
    d_tod = m_tod; d_mode = mode_12h; m_tick = 0; fire = 0;
    if (set_en) begin
      m_pre = 0;
      h = m_tod / 3600; m = (m_tod / 60) % 60;
      if (inc_hr)  h = (h + 1) % 24;
      if (inc_min) m = (m + 1) % 60;
      m_tod = h * 3600 + m * 60;
    end else if (m_pre == DIV - 1) begin
      m_pre = 0; m_tick = 1;
      m_tod = (m_tod + 1) % 86400;
      fire = m_valid && (m_tod == m_ahh * 3600 + m_amm * 60);
    end else begin
      m_pre++;
    end
    if (fire) m_alarm = 1;
    else if (alarm_ack) m_alarm = 0;
    if (alarm_we) begin
      m_valid = (alarm_hh <= 23) && (alarm_mm <= 59);
      if (m_valid) begin
        m_ahh = alarm_hh; m_amm = alarm_mm;
      end
    end
  endtask

  task automatic cyc(input bit hr = 0, input bit mn = 0, input bit we = 0, input bit ack = 0);
    inc_hr = hr; inc_min = mn; alarm_we = we; alarm_ack = ack;
    @(posedge clk_100MHz);
    model_edge();
    #1;
    inc_hr = 0; inc_min = 0; alarm_we = 0; alarm_ack = 0;
    expv = exp_vec();
  endtask

  // called 1 time unit after an edge; leaves reset high mid-cycle
  task automatic async_reset();
    #3 reset_pb = 1'b1;
    #1;
  endtask

  task automatic release_reset();
    reset_pb = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (obs !== RESET_VEC) begin bad++; $display("FAIL reset_state: got %h want %h", obs, RESET_VEC); end
    release_reset();
  endtask

  task automatic test_free_run();
    int ticks = 0, tick_at = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      total++;
      if (obs !== expv) begin bad++; $display("FAIL free_run c%0d: got %h want %h", i, obs, expv); end
      if (sec_tick) begin ticks++; tick_at = i; end
    end
    total++;
    if (ticks != 1 || tick_at != 10) begin
      bad++; $display("FAIL first_tick: got count=%0d at=%0d want count=1 at=10", ticks, tick_at);
    end
    cyc();
    total++;
    if (obs !== {4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL first_second_digits: got %h", obs);
    end
  endtask

  task automatic test_set_rollover();
    int rh = 11, rm = 59, guard = 0;
    bit hr, mn;
    set_en = 1'b1;
    cyc();
    while ((rh > 0 || rm > 0) && guard < 500) begin
      hr = (rh > 0) && ($urandom_range(0, 2) != 0);
      mn = (rm > 0) && ($urandom_range(0, 2) != 0);
      if (hr) rh--;
      if (mn) rm--;
      cyc(hr, mn);
      guard++;
      total++;
      if (obs !== expv) begin bad++; $display("FAIL set_inc: got %h want %h", obs, expv); end
    end
    cyc();
    total++;
    if (obs !== {4'd2, 4'd3, 4'd5, 4'd9, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL set_result: got %h want 23:59:00", obs);
    end
    set_en = 1'b0;
    for (int i = 0; i < 601; i++) begin
      cyc();
      total++;
      if (obs !== expv) begin bad++; $display("FAIL rollover c%0d: got %h want %h", i, obs, expv); end
    end
    mode_12h = 1'b1;
    cyc();
    total++;
    if (obs !== {4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL midnight_12h: got %h want 12:00:00 pm=0", obs);
    end
  endtask

  task automatic test_12h();
    set_en = 1'b1;
    cyc();
    for (int i = 0; i < 13; i++) begin
      cyc(1'b1, i == 5);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL set_hr13: got %h want %h", obs, expv); end
    end
    cyc();
    total++;
    if ({hrs_tens, hrs_ones, pm} !== {4'd0, 4'd1, 1'b1} || {min_tens, min_ones} !== {4'd0, 4'd1}) begin
      bad++; $display("FAIL hour13_12h: got %h want 0,1 pm=1 min=01", obs);
    end
    mode_12h = 1'b0;
    cyc();
    total++;
    if ({hrs_tens, hrs_ones, pm} !== {4'd1, 4'd3, 1'b0}) begin
      bad++; $display("FAIL hour13_24h: got %h want 1,3 pm=0", obs);
    end
    set_en = 1'b0;
  endtask

  task automatic test_alarm();
    int n = 0;
    bit ack, hit = 0;
    async_reset();
    total++;
    if (obs !== RESET_VEC) begin bad++; $display("FAIL reset_before_alarm: got %h", obs); end
    release_reset();
    alarm_hh = 5'd12; alarm_mm = 6'd1;
    cyc(0, 0, 1);
    while (!alarm && n < 700) begin
      cyc();
      n++;
      total++;
      if (obs !== expv) begin bad++; $display("FAIL alarm_run: got %h want %h", obs, expv); end
    end
    total++;
    if (!(alarm === 1'b1 && sec_tick === 1'b1)) begin
      bad++; $display("FAIL alarm_fire: got alarm=%b tick=%b after %0d want 1,1", alarm, sec_tick, n);
    end
    cyc();
    total++;
    if (obs !== {4'd1, 4'd2, 4'd0, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL alarm_time: got %h want 12:01:00 alarm=1", obs);
    end
    alarm_hh = 5'd12; alarm_mm = 6'd2;
    cyc(0, 0, 1);
    for (int i = 0; i < 700 && !hit; i++) begin
      ack = (m_pre == DIV - 1) && ((m_tod + 1) % 86400 == 12 * 3600 + 120);
      cyc(0, 0, 0, ack);
      hit = ack;
      total++;
      if (obs !== expv) begin bad++; $display("FAIL alarm_wait2: got %h want %h", obs, expv); end
    end
    total++;
    if (!hit || alarm !== 1'b1) begin
      bad++; $display("FAIL ack_vs_fire: got alarm=%b reached=%0d want alarm=1", alarm, hit);
    end
    cyc(0, 0, 0, 1);
    total++;
    if (alarm !== 1'b0) begin bad++; $display("FAIL ack_clear: got %b want 0", alarm); end
  endtask

  task automatic test_disarm();
    int rises = 0;
    alarm_hh = 5'd12; alarm_mm = 6'd3;
    cyc(0, 0, 1);
    alarm_hh = 5'd24;
    cyc(0, 0, 1);
    for (int i = 0; i < 700; i++) begin
      cyc();
      if (alarm) rises++;
      total++;
      if (obs !== expv) begin bad++; $display("FAIL disarm_run: got %h want %h", obs, expv); end
    end
    total++;
    if (rises != 0 || m_tod < 12 * 3600 + 180) begin
      bad++; $display("FAIL disarm: got alarm cycles=%0d want 0", rises);
    end
  endtask

  task automatic test_set_discard();
    int n = 0, gap = 0;
    while (m_pre != DIV - 1 && n < 20) begin cyc(); n++; end
    set_en = 1'b1;
    cyc();
    total++;
    if (sec_tick !== 1'b0 || obs !== expv) begin
      bad++; $display("FAIL set_discard: got %h want %h", obs, expv);
    end
    set_en = 1'b0;
    do begin cyc(); gap++; end while (!sec_tick && gap < 30);
    total++;
    if (gap != DIV) begin bad++; $display("FAIL set_release_gap: got %0d want %0d", gap, DIV); end
  endtask

  task automatic test_reset_mid();
    repeat ($urandom_range(3, 8)) cyc();
    async_reset();
    total++;
    if (obs !== RESET_VEC) begin bad++; $display("FAIL reset_midcount: got %h want %h", obs, RESET_VEC); end
    release_reset();
    set_en = 1'b1;
    mode_12h = 1'b1;
    repeat (4) cyc(1, 1);
    async_reset();
    total++;
    if (obs !== RESET_VEC) begin bad++; $display("FAIL reset_midset: got %h want %h", obs, RESET_VEC); end
    set_en = 1'b0;
    mode_12h = 1'b0;
    release_reset();
    for (int i = 0; i < 12; i++) begin
      cyc();
      total++;
      if (obs !== expv) begin bad++; $display("FAIL post_reset c%0d: got %h want %h", i, obs, expv); end
    end
  endtask

  task automatic test_random();
    bit hr, mn, we, ack;
    int nt;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) set_en = ~set_en;
      if ($urandom_range(0, 19) == 0) mode_12h = ~mode_12h;
      hr  = ($urandom_range(0, 3) == 0);
      mn  = ($urandom_range(0, 2) == 0);
      ack = ($urandom_range(0, 39) == 0);
      we  = ($urandom_range(0, 79) == 0);
      if (we) begin
        nt = (m_tod / 60 + 1) % 1440;
        alarm_hh = 5'(nt / 60);
        alarm_mm = 6'(nt % 60);
        if ($urandom_range(0, 3) == 0) alarm_mm = 6'($urandom_range(60, 63));
      end
      cyc(hr, mn, we, ack);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL random c%0d: got %h want %h", i, obs, expv); end
    end
    set_en = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_free_run();
    test_set_rollover();
    test_12h();
    test_alarm();
    test_disarm();
    test_set_discard();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
